rst_seq_ctrl: RTL and testbench

Reset sequencer for the I2C functional-model system. It takes the system reset plus three reset request sources (external pin, software, watchdog) and drives a staggered, per-domain active-low reset vector. Domain 0 (bus/clock infrastructure) is released first and the I2C master/slave domains follow. It replaces ad-hoc task-driven reset toggling in benches with a cycle-accurate, arbitrated sequence, and latches the reset cause for inspection.

---
 rtl/rst_seq_ctrl_if.sv | 23 ++
 rtl/rst_seq_ctrl.sv | 139 +++++++++++++
 tb/tb_rst_seq_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/rst_seq_ctrl_if.sv
// Reset sequencer bus: the three reset request sources, cause clear, and the per-domain reset vector with status.
interface rst_seq_ctrl_if #(
    parameter int N_DOM = 3
);
    logic             Ext_rst_n;
    logic             Sw_rst_req;
    logic             Wdt_rst_req;
    logic             Cause_clr;
    logic [N_DOM-1:0] Dom_rst_n;
    logic             Busy;
    logic             Rst_done;
    logic [3:0]       Rst_cause;

    modport master (
        output Ext_rst_n, Sw_rst_req, Wdt_rst_req, Cause_clr,
        input  Dom_rst_n, Busy, Rst_done, Rst_cause
    );

    modport slave (
        input  Ext_rst_n, Sw_rst_req, Wdt_rst_req, Cause_clr,
        output Dom_rst_n, Busy, Rst_done, Rst_cause
    );
endinterface

// File: rtl/rst_seq_ctrl.sv
// Staggered per-domain reset sequencer: hold after the last request, then release domains 0..N_DOM-1 in order.
// Optional RST_CAUSE_EN macro adds the sticky {wdt, sw, ext, por} cause register.
module rst_seq_ctrl #(
    parameter int N_DOM       = 3,
    parameter int HOLD_CYC    = 16,
    parameter int STEP_CYC    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic          Clk,
    input  logic          Rst_n,
    rst_seq_ctrl_if.slave bus
);
    localparam int HW = $clog2(HOLD_CYC + 1);
    localparam int SW = $clog2(STEP_CYC + 1);
    localparam int IW = $clog2(N_DOM + 1);

    localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD_CYC - 1);
    localparam logic [SW-1:0]    STEP_LAST = SW'(STEP_CYC - 1);
    localparam logic [IW-1:0]    IDX_LAST  = IW'(N_DOM - 1);
    localparam logic [N_DOM-1:0] ONE       = N_DOM'(1);

    typedef enum logic [1:0] {HOLD, RELEASE, RUN} state_t;

    state_t                 state;
    logic [HW-1:0]          hold_cnt;
    logic [SW-1:0]          step_cnt;
    logic [IW-1:0]          idx;
    logic [N_DOM-1:0]       dom_q;
    logic                   busy_q;
    logic                   done_q;
    logic [SYNC_STAGES-1:0] ext_sync;
    logic                   ext_req;
    logic                   req;

    // Chain carries the external request active-high, so it powers up deasserted.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) ext_sync <= '0;
        else        ext_sync <= {ext_sync[SYNC_STAGES-2:0], ~bus.Ext_rst_n};
    end

    assign ext_req = ext_sync[SYNC_STAGES-1];
    assign req     = ext_req | bus.Sw_rst_req | bus.Wdt_rst_req;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= HOLD;
            hold_cnt <= '0;
            step_cnt <= '0;
            idx      <= '0;
            dom_q    <= '0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                HOLD: begin
                    if (req) begin
                        hold_cnt <= '0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        dom_q    <= ONE;
                        hold_cnt <= '0;
                        step_cnt <= '0;
                        idx      <= IW'(1);
                        if (N_DOM == 1) begin
                            state  <= RUN;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            state  <= RELEASE;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    // Abort re-asserts every domain so no high domain sits above a low one.
                    if (req) begin
                        state    <= HOLD;
                        dom_q    <= '0;
                        busy_q   <= 1'b1;
                        hold_cnt <= '0;
                        step_cnt <= '0;
                        idx      <= '0;
                    end else if (step_cnt == STEP_LAST) begin
                        dom_q    <= dom_q | (ONE << idx);
                        step_cnt <= '0;
                        idx      <= idx + 1'b1;
                        if (idx == IDX_LAST) begin
                            state  <= RUN;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end
                    end else begin
                        step_cnt <= step_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (req) begin
                        state    <= HOLD;
                        dom_q    <= '0;
                        busy_q   <= 1'b1;
                        hold_cnt <= '0;
                        step_cnt <= '0;
                        idx      <= '0;
                    end
                end
                default: begin
                    state  <= HOLD;
                    dom_q  <= '0;
                    busy_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.Dom_rst_n = dom_q;
    assign bus.Busy      = busy_q;
    assign bus.Rst_done  = done_q;

`ifdef RST_CAUSE_EN
    logic [3:0] cause_q;
    logic       cause_clr_run;

    assign cause_clr_run = (state == RUN) && bus.Cause_clr;

    // A set on the clearing edge survives because the set bits are ORed after the clear.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) cause_q <= 4'b0001;
        else        cause_q <= (cause_clr_run ? 4'b0000 : cause_q)
                               | {bus.Wdt_rst_req, bus.Sw_rst_req, ext_req, 1'b0};
    end

    assign bus.Rst_cause = cause_q;
`else
    logic unused_cause_clr;
    assign unused_cause_clr = bus.Cause_clr;
    assign bus.Rst_cause    = 4'b0000;
`endif
endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl with default parameters; cause expectations follow RST_CAUSE_EN.
module tb_rst_seq_ctrl;
    logic clk;
    logic rst_n;
    int   n_chk  = 0;
    int   n_pass = 0;

    rst_seq_ctrl_if #(.N_DOM(3)) bus();

    rst_seq_ctrl #(
        .N_DOM(3), .HOLD_CYC(16), .STEP_CYC(4), .SYNC_STAGES(2)
    ) dut (
        .Clk   (clk),
        .Rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] exp_cause(input logic [3:0] v);
`ifdef RST_CAUSE_EN
        return v;
`else
        return 4'b0000 & v;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // k counts edges from the first non-request edge; release expected at 16/20/24.
    task automatic check_seq(input string tag, input int k0);
        int dones = 0;
        for (int k = k0; k <= 25; k++) begin
            step();
            if (bus.Rst_done === 1'b1) dones++;
            case (k)
                15: chk({tag, "_d15"}, 32'(bus.Dom_rst_n), 32'h0);
                16: chk({tag, "_d16"}, 32'(bus.Dom_rst_n), 32'h1);
                19: chk({tag, "_d19"}, 32'(bus.Dom_rst_n), 32'h1);
                20: chk({tag, "_d20"}, 32'(bus.Dom_rst_n), 32'h3);
                23: begin
                    chk({tag, "_d23"}, 32'(bus.Dom_rst_n), 32'h3);
                    chk({tag, "_busy23"}, 32'(bus.Busy), 32'h1);
                    chk({tag, "_done23"}, 32'(bus.Rst_done), 32'h0);
                end
                24: begin
                    chk({tag, "_d24"}, 32'(bus.Dom_rst_n), 32'h7);
                    chk({tag, "_busy24"}, 32'(bus.Busy), 32'h0);
                    chk({tag, "_done24"}, 32'(bus.Rst_done), 32'h1);
                end
                25: chk({tag, "_done25"}, 32'(bus.Rst_done), 32'h0);
                default: ;
            endcase
        end
        chk({tag, "_ndone"}, 32'(dones), 32'd1);
    endtask

    task automatic sw_pulse();
        bus.Sw_rst_req = 1'b1;
        step();
        bus.Sw_rst_req = 1'b0;
    endtask

    initial begin
        int bad;
        int dones;
        rst_n           = 1'b0;
        bus.Ext_rst_n   = 1'b1;
        bus.Sw_rst_req  = 1'b0;
        bus.Wdt_rst_req = 1'b0;
        bus.Cause_clr   = 1'b0;
        #23;
        chk("rst_dom",   32'(bus.Dom_rst_n), 32'h0);
        chk("rst_busy",  32'(bus.Busy), 32'h1);
        chk("rst_done",  32'(bus.Rst_done), 32'h0);
        chk("rst_cause", 32'(bus.Rst_cause), 32'(exp_cause(4'b0001)));

        // Power-on release
        @(negedge clk);
        rst_n = 1'b1;
        check_seq("por", 1);
        chk("por_cause", 32'(bus.Rst_cause), 32'(exp_cause(4'b0001)));

        // Software request from RUN
        sw_pulse();
        chk("sw_dom0",  32'(bus.Dom_rst_n), 32'h0);
        chk("sw_busy",  32'(bus.Busy), 32'h1);
        check_seq("sw", 1);
        chk("sw_cause", 32'(bus.Rst_cause), 32'(exp_cause(4'b0101)));

        // Watchdog abort on edge 18, domain 0 already released
        sw_pulse();
        dones = 0;
        for (int k = 1; k <= 17; k++) begin
            step();
            if (bus.Rst_done === 1'b1) dones++;
        end
        chk("wdt_pre", 32'(bus.Dom_rst_n), 32'h1);
        bus.Wdt_rst_req = 1'b1;
        step();
        bus.Wdt_rst_req = 1'b0;
        chk("wdt_abort", 32'(bus.Dom_rst_n), 32'h0);
        chk("wdt_busy",  32'(bus.Busy), 32'h1);
        chk("wdt_nodone", 32'(dones), 32'd0);
        check_seq("wdt", 1);
        chk("wdt_cause", 32'(bus.Rst_cause), 32'(exp_cause(4'b1101)));

        // External pin low for 50 edges
        bus.Ext_rst_n = 1'b0;
        step();
        step();
        chk("ext_lat2", 32'(bus.Dom_rst_n), 32'h7);
        step();
        chk("ext_lat3", 32'(bus.Dom_rst_n), 32'h0);
        chk("ext_busy", 32'(bus.Busy), 32'h1);
        bad = 0;
        for (int k = 0; k < 47; k++) begin
            step();
            if (bus.Dom_rst_n !== 3'b000) bad++;
        end
        chk("ext_held", 32'(bad), 32'd0);
        bus.Ext_rst_n = 1'b1;
        step();
        step();
        chk("ext_sync", 32'(bus.Dom_rst_n), 32'h0);
        check_seq("ext", 1);
        chk("ext_cause", 32'(bus.Rst_cause), 32'(exp_cause(4'b1111)));

        // Clear and software request on the same RUN edge; set wins
        bus.Cause_clr = 1'b1;
        sw_pulse();
        bus.Cause_clr = 1'b0;
        chk("clr_sw_cause", 32'(bus.Rst_cause), 32'(exp_cause(4'b0100)));
        chk("clr_sw_dom",   32'(bus.Dom_rst_n), 32'h0);
        // Clear outside RUN is ignored
        bus.Cause_clr = 1'b1;
        step();
        bus.Cause_clr = 1'b0;
        chk("clr_hold_cause", 32'(bus.Rst_cause), 32'(exp_cause(4'b0100)));
        check_seq("clr", 2);
        bus.Cause_clr = 1'b1;
        step();
        bus.Cause_clr = 1'b0;
        chk("clr_run_cause", 32'(bus.Rst_cause), 32'h0);
        chk("clr_run_dom",   32'(bus.Dom_rst_n), 32'h7);

        // Power-on reset in the middle of RELEASE
        sw_pulse();
        for (int k = 1; k <= 18; k++) step();
        chk("mid_pre", 32'(bus.Dom_rst_n), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_dom",   32'(bus.Dom_rst_n), 32'h0);
        chk("mid_busy",  32'(bus.Busy), 32'h1);
        chk("mid_done",  32'(bus.Rst_done), 32'h0);
        chk("mid_cause", 32'(bus.Rst_cause), 32'(exp_cause(4'b0001)));
        @(negedge clk);
        rst_n = 1'b1;
        check_seq("mid", 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
